// File: rtl/draw_scheduler.sv
// Round-robin arbiter sharing one VGA plot port among NUM_REQ pixel-drawing engines.
// Each grant clears the engine, enables it until done or watchdog timeout, then pulses ack.
module draw_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_CYCLES = 1100,
   parameter int unsigned GW         = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   output logic [NUM_REQ-1:0]   ack,
   output logic                 err,
   output logic [NUM_REQ-1:0]   eng_clear,
   output logic [NUM_REQ-1:0]   eng_enable,
   input  logic [NUM_REQ-1:0]   eng_done,
   input  logic [NUM_REQ*9-1:0] eng_x,
   input  logic [NUM_REQ*8-1:0] eng_y,
   input  logic [NUM_REQ*3-1:0] eng_colour,
   output logic [8:0]           vga_x,
   output logic [7:0]           vga_y,
   output logic [2:0]           vga_colour,
   output logic                 vga_plot,
   output logic                 busy,
   output logic [GW-1:0]        grant_id
);

   localparam int unsigned WdW = $clog2(MAX_CYCLES + 1);
   localparam logic [WdW-1:0] WdLast = WdW'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StClear, StDraw, StFinish} state_e;

   state_e         state_q;
   logic [GW-1:0]  last_grant_q;
   logic [WdW-1:0] watchdog_q;
   logic           abort_q;

   logic [GW-1:0]  next_grant;
   logic           next_valid;
   logic [GW-1:0]  cand;
   logic [8:0]     sel_x;
   logic [7:0]     sel_y;
   logic [2:0]     sel_colour;
   logic           sel_done;

   // Search starts just after the last grant and wraps, giving rotating priority.
   always_comb begin
      next_grant = last_grant_q;
      next_valid = 1'b0;
      cand       = last_grant_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = (cand == GW'(NUM_REQ - 1)) ? '0 : cand + GW'(1);
         if (!next_valid && req[cand]) begin
            next_grant = cand;
            next_valid = 1'b1;
         end
      end
   end

   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      sel_done   = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_id == GW'(i)) begin
            sel_x      = eng_x[9*i +: 9];
            sel_y      = eng_y[8*i +: 8];
            sel_colour = eng_colour[3*i +: 3];
            sel_done   = eng_done[i];
         end
      end
   end

   always_comb begin
      eng_clear  = '0;
      eng_enable = '0;
      ack        = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_id == GW'(i)) begin
            eng_clear[i]  = (state_q == StClear);
            eng_enable[i] = (state_q == StDraw);
            ack[i]        = (state_q == StFinish);
         end
      end
      err = (state_q == StFinish) && abort_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         grant_id     <= '0;
         last_grant_q <= GW'(NUM_REQ - 1);
         watchdog_q   <= '0;
         abort_q      <= 1'b0;
         vga_x        <= '0;
         vga_y        <= '0;
         vga_colour   <= '0;
         vga_plot     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         vga_plot <= 1'b0;
         case (state_q)
            StIdle: begin
               if (next_valid) begin
                  grant_id <= next_grant;
                  busy     <= 1'b1;
                  state_q  <= StClear;
               end
            end
            StClear: begin
               watchdog_q <= '0;
               state_q    <= StDraw;
            end
            StDraw: begin
               watchdog_q <= watchdog_q + WdW'(1);
               vga_plot   <= ~sel_done;
               // Coordinates only follow the engine while it is still plotting.
               if (!sel_done) begin
                  vga_x      <= sel_x;
                  vga_y      <= sel_y;
                  vga_colour <= sel_colour;
               end
               if (sel_done) begin
                  abort_q <= 1'b0;
                  state_q <= StFinish;
               end else if (watchdog_q == WdLast) begin
                  abort_q <= 1'b1;
                  state_q <= StFinish;
               end
            end
            StFinish: begin
               last_grant_q <= grant_id;
               busy         <= 1'b0;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_scheduler.sv
// Randomised bench for draw_scheduler: behavioural engines plus a transaction-level
// model predicting grant order, plotted pixel stream, ack/err and enable cycle counts.
module tb_draw_scheduler;

   localparam int NR  = 4;
   localparam int MAX = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [NR-1:0] req;
   logic [NR-1:0] ack;
   logic          err;
   logic [NR-1:0] eng_clear;
   logic [NR-1:0] eng_enable;
   logic [NR-1:0] eng_done;
   logic [NR*9-1:0] eng_x;
   logic [NR*8-1:0] eng_y;
   logic [NR*3-1:0] eng_colour;
   logic [8:0]    vga_x;
   logic [7:0]    vga_y;
   logic [2:0]    vga_colour;
   logic          vga_plot;
   logic          busy;
   logic [1:0]    grant_id;

   draw_scheduler #(
      .NUM_REQ   (NR),
      .MAX_CYCLES(MAX),
      .GW        (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .ack       (ack),
      .err       (err),
      .eng_clear (eng_clear),
      .eng_enable(eng_enable),
      .eng_done  (eng_done),
      .eng_x     (eng_x),
      .eng_y     (eng_y),
      .eng_colour(eng_colour),
      .vga_x     (vga_x),
      .vga_y     (vga_y),
      .vga_colour(vga_colour),
      .vga_plot  (vga_plot),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 clk = ~clk;

   // Engine configuration (bench-owned) and engine state (engine-process-owned).
   int cfg_w [NR] = '{1, 1, 1, 1};
   int cfg_h [NR] = '{1, 1, 1, 1};
   int cfg_x [NR] = '{0, 0, 0, 0};
   int cfg_y [NR] = '{0, 0, 0, 0};
   int cfg_c [NR] = '{0, 0, 0, 0};
   bit cfg_nd[NR] = '{0, 0, 0, 0};
   int stale_gen[NR] = '{0, 0, 0, 0};
   int clr_gen  [NR] = '{0, 0, 0, 0};
   int e_cnt    [NR] = '{0, 0, 0, 0};
   bit e_dn     [NR] = '{0, 0, 0, 0};

   always @(posedge clk) begin
      for (int i = 0; i < NR; i++) begin
         if (eng_clear[i]) begin
            e_cnt[i]   <= 0;
            e_dn[i]    <= 1'b0;
            clr_gen[i] <= stale_gen[i];
         end else if (eng_enable[i] && !e_dn[i]) begin
            e_cnt[i] <= e_cnt[i] + 1;
            if (!cfg_nd[i] && (e_cnt[i] + 1 == cfg_w[i] * cfg_h[i])) e_dn[i] <= 1'b1;
         end
      end
   end

   always_comb begin
      eng_done   = '0;
      eng_x      = '0;
      eng_y      = '0;
      eng_colour = '0;
      for (int i = 0; i < NR; i++) begin
         eng_done[i]          = e_dn[i] | (stale_gen[i] != clr_gen[i]);
         eng_x[9*i +: 9]      = 9'(cfg_x[i] + e_cnt[i] % cfg_w[i]);
         eng_y[8*i +: 8]      = 8'(cfg_y[i] + e_cnt[i] / cfg_w[i]);
         eng_colour[3*i +: 3] = 3'(cfg_c[i]);
      end
   end

   int n_cmp = 0;
   int n_err = 0;
   logic [19:0] last_pix = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Round-robin: first requester after the last grant, wrapping.
   function automatic int rr(input logic [NR-1:0] r, input int last);
      for (int i = 1; i <= NR; i++) begin
         if (r[(last + i) % NR]) return (last + i) % NR;
      end
      return -1;
   endfunction

   // Follows one grant from clear to ack; returns at the negedge where ack is seen.
   task automatic serve(input int g, input int drop_at);
      int n, npix, k, en, stray, clears, ex, ey;
      bit exp_abort, got;
      n         = cfg_nd[g] ? 100000 : cfg_w[g] * cfg_h[g];
      exp_abort = (n >= MAX);
      npix      = (n < MAX) ? n : MAX;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (eng_clear != 0) got = 1;
      end
      check_eq("clear_seen", 32'(got), 1);
      if (!got) return;
      check_eq("clear_onehot", 32'(eng_clear), 32'(1) << g);
      check_eq("grant_id", 32'(grant_id), 32'(g));
      check_eq("busy_clear", 32'(busy), 1);
      k = 0; en = 0; stray = 0; clears = 0; got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (eng_enable == NR'(1 << g)) en++;
         else if (eng_enable != 0) stray++;
         if (eng_clear != 0) clears++;
         if (vga_plot) begin
            if (k < npix) begin
               ex       = cfg_x[g] + k % cfg_w[g];
               ey       = cfg_y[g] + k / cfg_w[g];
               last_pix = {9'(ex), 8'(ey), 3'(cfg_c[g])};
               check_eq("plot_pixel", 32'({vga_x, vga_y, vga_colour}), 32'(last_pix));
            end
            k++;
         end
         if (drop_at >= 0 && en == drop_at && eng_enable != 0) req[g] = 1'b0;
         if (ack != 0) got = 1;
      end
      check_eq("ack_seen", 32'(got), 1);
      if (!got) return;
      check_eq("ack_onehot", 32'(ack), 32'(1) << g);
      check_eq("err", 32'(err), 32'(exp_abort));
      check_eq("pixels", 32'(k), 32'(npix));
      check_eq("enable_cycles", 32'(en), 32'(exp_abort ? MAX : n + 1));
      check_eq("enable_stray", 32'(stray), 0);
      check_eq("reclear", 32'(clears), 0);
      check_eq("busy_at_ack", 32'(busy), 1);
   endtask

   task automatic idle_check();
      @(negedge clk);
      check_eq("busy_after_ack", 32'(busy), 0);
      check_eq("ack_single", 32'(ack), 0);
      check_eq("vga_hold", 32'({vga_x, vga_y, vga_colour}), 32'(last_pix));
   endtask

   task automatic set_cfg(input int i, input int w, input int h, input int x, input int y,
                          input int c, input bit nd);
      cfg_w[i] = w; cfg_h[i] = h; cfg_x[i] = x; cfg_y[i] = y; cfg_c[i] = c; cfg_nd[i] = nd;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int k, g, last_m;
      bit got;
      int seq[5] = '{0, 1, 2, 3, 0};
      reset = 1'b1;
      req   = '0;
      set_cfg(0, 2, 2, 10, 20, 5, 0);
      set_cfg(1, 3, 2, 100, 50, 3, 0);
      set_cfg(2, 1, 3, 200, 7, 6, 0);
      set_cfg(3, 2, 1, 300, 230, 1, 0);
      repeat (2) @(negedge clk);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_plot", 32'(vga_plot), 0);
      check_eq("rst_vga", 32'({vga_x, vga_y, vga_colour}), 0);
      check_eq("rst_grant", 32'(grant_id), 0);
      check_eq("rst_decoded", 32'({ack, err, eng_clear, eng_enable}), 0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("idle_busy", 32'(busy), 0);

      // T1: single request on engine 0.
      req = 4'b0001;
      serve(0, -1);
      req = '0;
      idle_check();

      // T5: reset after five pixels of engine 1.
      req = 4'b0010;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (eng_clear != 0) got = 1;
      end
      check_eq("t5_clear", 32'(eng_clear), 32'b0010);
      k = 0;
      for (int c = 0; c < 20 && k < 5; c++) begin
         @(negedge clk);
         if (vga_plot) k++;
      end
      check_eq("t5_pixels", 32'(k), 5);
      reset = 1'b1;
      #1;
      check_eq("t5_plot", 32'(vga_plot), 0);
      check_eq("t5_enable", 32'(eng_enable), 0);
      check_eq("t5_busy", 32'(busy), 0);
      check_eq("t5_ack", 32'({ack, err}), 0);
      req = 4'b1111;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      last_pix = '0;

      // T2: all requests held, rotation from 0 after reset.
      for (int j = 0; j < 5; j++) begin
         serve(seq[j], -1);
         if (j == 4) req = '0;
         idle_check();
      end

      // T3: engine 2 never finishes.
      cfg_nd[2] = 1'b1;
      req = 4'b0100;
      serve(2, -1);
      req = '0;
      idle_check();
      cfg_nd[2] = 1'b0;

      // T4: stale done on engine 1 must be cleared first.
      stale_gen[1] = stale_gen[1] + 1;
      @(negedge clk);
      req = 4'b0010;
      serve(1, -1);
      req = '0;
      idle_check();

      // T6: engine 3 request dropped two cycles into the draw.
      set_cfg(3, 2, 3, 40, 60, 2, 0);
      req = 4'b1000;
      serve(3, 2);
      req = '0;
      idle_check();
      last_m = 3;

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < NR; i++) begin
            set_cfg(i, $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(0, 300),
                    $urandom_range(0, 220), $urandom_range(0, 7), $urandom_range(0, 9) == 0);
         end
         if (req == 0) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               check_eq("idle_busy", 32'(busy), 0);
            end
            req = 4'($urandom_range(1, 15));
         end
         g = rr(req, last_m);
         serve(g, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
         last_m = g;
         req[g] = 1'b0;
         req = req | (4'($urandom) & 4'($urandom));
         idle_check();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
